// File: rtl/fwd_pkg.sv
// fwd_pkg: shared operand-source encodings, hold FSM states and helpers
package fwd_pkg;
  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_HOLD = 2'b11;
  typedef enum logic {ST_IDLE, ST_HELD} state_t;
  function automatic logic is_fwd(logic [1:0] s);
    return s == FWD_WB || s == FWD_MEM;
  endfunction
endpackage

// File: rtl/fwd_operand_slice.sv
// fwd_operand_slice: resolves one ALU operand and holds it across an EX stall
module fwd_operand_slice import fwd_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              mem_regwrite_i,
  input  logic [REG_AW-1:0] mem_rd_addr_i,
  input  logic [DATA_W-1:0] mem_alu_out_i,
  input  logic              wb_regwrite_i,
  input  logic [REG_AW-1:0] wb_rd_addr_i,
  input  logic [DATA_W-1:0] wb_write_data_i,
  output logic [DATA_W-1:0] out_o,
  output logic [1:0]        sel_o
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d, live;
  logic [1:0] live_sel;
  logic mem_hit, wb_hit;
  assign mem_hit  = mem_regwrite_i && mem_rd_addr_i != '0 && mem_rd_addr_i == src_addr_i;
  assign wb_hit   = wb_regwrite_i && wb_rd_addr_i != '0 && wb_rd_addr_i == src_addr_i;
  assign live     = mem_hit ? mem_alu_out_i : wb_hit ? wb_write_data_i : reg_data_i;
  assign live_sel = mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_REG;
  assign out_o    = state_q == ST_HELD ? hold_q : live;
  assign sel_o    = state_q == ST_HELD ? FWD_HOLD : live_sel;
  // capture the live operand on the first stalled edge; drop it on release or flush
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (flush_i) state_d = ST_IDLE;
    else if (state_q == ST_IDLE && stall_i) begin
      state_d = ST_HELD;
      hold_d  = live;
    end else if (state_q == ST_HELD && !stall_i) state_d = ST_IDLE;
  end
  // hold state and captured operand registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end
endmodule

// File: rtl/fwd_operand_unit.sv
// fwd_operand_unit: EX-stage operand forwarding, load-use detection and event count
module fwd_operand_unit import fwd_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ex_rs_addr,
  input  logic [REG_AW-1:0] ex_rt_addr,
  input  logic [DATA_W-1:0] ex_rs_data,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic              ex_stall,
  input  logic              ex_flush,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_alu_out,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic [DATA_W-1:0] fa_out,
  output logic [DATA_W-1:0] fb_out,
  output logic [1:0]        fa_sel,
  output logic [1:0]        fb_sel,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  fwd_count
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic fwd_evt;
  fwd_operand_slice #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_a (
    .clk(clk), .rst(rst), .src_addr_i(ex_rs_addr), .reg_data_i(ex_rs_data),
    .stall_i(ex_stall), .flush_i(ex_flush),
    .mem_regwrite_i(mem_regwrite), .mem_rd_addr_i(mem_rd_addr), .mem_alu_out_i(mem_alu_out),
    .wb_regwrite_i(wb_regwrite), .wb_rd_addr_i(wb_rd_addr), .wb_write_data_i(wb_write_data),
    .out_o(fa_out), .sel_o(fa_sel)
  );
  fwd_operand_slice #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_b (
    .clk(clk), .rst(rst), .src_addr_i(ex_rt_addr), .reg_data_i(ex_rt_data),
    .stall_i(ex_stall), .flush_i(ex_flush),
    .mem_regwrite_i(mem_regwrite), .mem_rd_addr_i(mem_rd_addr), .mem_alu_out_i(mem_alu_out),
    .wb_regwrite_i(wb_regwrite), .wb_rd_addr_i(wb_rd_addr), .wb_write_data_i(wb_write_data),
    .out_o(fb_out), .sel_o(fb_sel)
  );
  assign load_use_stall = ex_memread && ex_rd_addr != '0 &&
                          (ex_rd_addr == id_rs_addr || ex_rd_addr == id_rt_addr);
  assign fwd_evt   = !ex_stall && !ex_flush && (is_fwd(fa_sel) || is_fwd(fb_sel));
  assign fwd_count = cnt_q;
  // count at most one forwarding event per advancing cycle, saturating
  always_comb begin
    cnt_d = fwd_evt && cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
  end
  // forwarding event counter register
  always_ff @(posedge clk) begin
    cnt_q <= rst ? '0 : cnt_d;
  end
endmodule
